// File: rtl/mem_access_unit.sv
// Multi-cycle load/store initiator between execute stage and word-indexed data RAM.
// Optional build macro MISALIGN_TRAP_EN enables alignment/range faults with resp_err.
module mem_access_unit #(
    parameter int RAM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_addr,
    output logic [31:0] write_ram_data,
    output logic [1:0]  write_ram_flag,
    output logic [2:0]  read_ram_flag,
    input  logic [31:0] ram_out
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic        accept;
    logic        fault;

    // Replace the addressed lanes of the captured word; size 1x is a whole-word store.
    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00:   r[8*off +: 8]     = wd[7:0];
            2'b01:   r[16*off[1] +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                 input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*off +: 8];
        h = word[16*off[1] +: 16];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

`ifdef MISALIGN_TRAP_EN
    localparam logic [29:0] RAM_WORDS_W = 30'(RAM_WORDS);
    assign fault = (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                || (req_size == 2'b11)
                || (req_addr[31:2] >= RAM_WORDS_W);
`else
    logic unused_ram_words;
    assign unused_ram_words = (RAM_WORDS != 0);
    assign fault = 1'b0;
`endif

    assign accept = (state_q == S_IDLE) && req_valid;

    always_comb begin
        state_d = state_q;
        we_d    = accept ? req_we       : we_q;
        size_d  = accept ? req_size     : size_q;
        uns_d   = accept ? req_unsigned : uns_q;
        err_d   = accept ? fault        : err_q;
        addr_d  = accept ? req_addr     : addr_q;
        wdata_d = accept ? req_wdata    : wdata_q;
        word_d  = (state_q == S_RD) ? ram_out : word_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                if (fault)                      state_d = S_RESP;
                else if (req_we && req_size[1]) state_d = S_WR;
                else                            state_d = S_RD;
            end
            S_RD:    state_d = we_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
        err_q   <= err_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        word_q  <= word_d;
    end

    // All outputs decode from the registered state so reset leaves them quiet.
    always_comb begin
        req_ready      = (state_q == S_IDLE);
        resp_valid     = (state_q == S_RESP);
        resp_err       = (state_q == S_RESP) && err_q;
        resp_rdata     = 32'd0;
        if (state_q == S_RESP && !we_q && !err_q)
            resp_rdata = extract_load(word_q, size_q, uns_q, addr_q[1:0]);
        read_ram_flag  = (state_q == S_RD) ? 3'b001 : 3'b000;
        write_ram_flag = (state_q == S_WR) ? 2'b01 : 2'b00;
        ram_addr       = (state_q == S_RD || state_q == S_WR) ? {2'b00, addr_q[31:2]} : 32'd0;
        write_ram_data = (state_q == S_WR) ? merge_store(word_q, wdata_q, size_q, addr_q[1:0]) : 32'd0;
    end
endmodule
